// File: rtl/sensor_hub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_hub_pkg
// Brief    : Shared constants, FSM state type and helpers for the sensor hub
//            packet path (optional PKT_CHECKSUM_EN adds the CHK state).
// Revision : 1.0 - initial release
// ============================================================================
package sensor_hub_pkg;

    localparam logic [7:0] c_sync_byte_default = 8'hA5;
    localparam int         c_pkt_len_base      = 4;
    localparam int         c_pkt_len_chk       = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_ID   = 3'd2,
        ST_MSB  = 3'd3,
`ifdef PKT_CHECKSUM_EN
        ST_LSB  = 3'd4,
        ST_CHK  = 3'd5
`else
        ST_LSB  = 3'd4
`endif
    } state_t;

    // A single channel still needs a 1-bit index.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin grant; search starts just above ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    // Scanning from the farthest offset down lets the nearest requester win.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N_CH]) begin
                grant                          = '0;
                grant[(int'(ptr) + k) % N_CH]  = 1'b1;
                idx                            = IDX_W'((int'(ptr) + k) % N_CH);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkt_arbiter
// Brief    : Round-robin share of one UART byte transmitter among N_CH sample
//            channels; frames sync/id/msb/lsb[/checksum with PKT_CHECKSUM_EN].
// Revision : 1.0 - initial release
// ============================================================================
module uart_pkt_arbiter
    import sensor_hub_pkg::*;
#(
    parameter int         N_CH      = 4,
    parameter logic [7:0] SYNC_BYTE = c_sync_byte_default
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CH-1:0]              req_valid,
    input  logic [16*N_CH-1:0]           req_data,
    output logic [N_CH-1:0]              req_ready,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic [ch_idx_w(N_CH)-1:0]    grant_id
);

    localparam int c_idx_w = ch_idx_w(N_CH);

    state_t               r_state;
    logic [15:0]          r_sample;
    logic [c_idx_w-1:0]   r_grant_id;
    logic [c_idx_w-1:0]   r_ptr;
    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;

    logic [N_CH-1:0]      w_grant;
    logic [c_idx_w-1:0]   w_idx;
    logic [15:0]          w_sel_data;
    logic                 w_any;
    logic                 w_xfer;

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (c_idx_w)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant[i]) w_sel_data = req_data[16*i +: 16];
        end
    end

    assign w_any  = |req_valid;
    assign w_xfer = r_tx_valid && tx_ready;

    // Gated by rst_n so the capture strobe is quiet while reset is held.
    assign req_ready = (r_state == ST_IDLE && rst_n) ? w_grant : '0;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sample   <= '0;
            r_grant_id <= '0;
            r_ptr      <= c_idx_w'(N_CH - 1);
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sample   <= w_sel_data;
                        r_grant_id <= w_idx;
                        r_ptr      <= w_idx;
                        r_tx_data  <= SYNC_BYTE;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_xfer) begin
                        r_tx_data <= 8'(r_grant_id);
                        r_state   <= ST_ID;
                    end
                end
                ST_ID: begin
                    if (w_xfer) begin
                        r_tx_data <= r_sample[15:8];
                        r_state   <= ST_MSB;
                    end
                end
                ST_MSB: begin
                    if (w_xfer) begin
                        r_tx_data <= r_sample[7:0];
                        r_state   <= ST_LSB;
                    end
                end
`ifdef PKT_CHECKSUM_EN
                ST_LSB: begin
                    if (w_xfer) begin
                        r_tx_data <= 8'(r_grant_id) ^ r_sample[15:8] ^ r_sample[7:0];
                        r_state   <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (w_xfer) begin
                        r_tx_data  <= 8'h00;
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
`else
                ST_LSB: begin
                    if (w_xfer) begin
                        r_tx_data  <= 8'h00;
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_tx_data  <= 8'h00;
                    r_tx_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_pkt_arbiter
// Brief    : Self-checking bench for uart_pkt_arbiter (N_CH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_pkt_arbiter;

`ifdef PKT_CHECKSUM_EN
    localparam int c_pkt_len = 5;
`else
    localparam int c_pkt_len = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [1:0]  grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_pkt_arbiter #(.N_CH(4), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] data;
        int          exp_ch;
        logic [15:0] exp_word;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Packet bytes MSB-first: sync, id, msb, lsb, checksum (last only if enabled).
    function automatic logic [39:0] pkt_bytes(input int ch, input logic [15:0] w);
        logic [7:0] id;
        id = 8'(ch);
        return {8'hA5, id, w[15:8], w[7:0], id ^ w[15:8] ^ w[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Expects the DUT idle with ch winning arbitration; tx_ready must be high.
    task automatic run_packet(input int ch, input logic [15:0] w,
                              input bit chg, input logic [15:0] chg_val);
        logic [39:0] p;
        logic [3:0]  oh;
        p  = pkt_bytes(ch, w);
        oh = 4'(1 << ch);
        @(negedge clk);
        chk("idle_req_ready", req_ready, oh);
        chk("idle_busy", busy, 0);
        chk("idle_tx_valid", tx_valid, 0);
        tick();
        if (chg) req_data[16*ch +: 16] = chg_val;
        for (int i = 0; i < c_pkt_len; i++) begin
            @(negedge clk);
            chk("pkt_tx_valid", tx_valid, 1);
            chk("pkt_tx_data", tx_data, p[39-8*i -: 8]);
            chk("pkt_busy", busy, 1);
            chk("pkt_grant_id", grant_id, ch);
            chk("pkt_req_ready", req_ready, 0);
            tick();
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (busy && t < 20) begin
            tick();
            t++;
        end
        chk("drain_timeout", busy, 0);
    endtask

    // Behavioural reference: queue of bytes still owed, plus round-robin pointer.
    task automatic random_test(input int cycles);
        logic [7:0]  q[$];
        logic [39:0] p;
        int          mptr, mgid, g;
        bit          found;
        logic [3:0]  exp_ready;
        do_reset();
        mptr = 3;
        mgid = 0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            req_valid = 4'($urandom);
            req_data  = {$urandom, $urandom};
            tx_ready  = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            found = 1'b0;
            g     = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && req_valid[(mptr + k) % 4]) begin
                    g     = (mptr + k) % 4;
                    found = 1'b1;
                end
            end
            exp_ready = (q.size() == 0 && found) ? 4'(1 << g) : 4'b0;
            chk("rnd_tx_valid", tx_valid, (q.size() > 0));
            chk("rnd_busy", busy, (q.size() > 0));
            chk("rnd_req_ready", req_ready, exp_ready);
            chk("rnd_grant_id", grant_id, mgid);
            if (q.size() > 0) chk("rnd_tx_data", tx_data, q[0]);
            if (q.size() == 0) begin
                if (found) begin
                    p = pkt_bytes(g, req_data[16*g +: 16]);
                    for (int i = 0; i < c_pkt_len; i++) q.push_back(p[39-8*i -: 8]);
                    mptr = g;
                    mgid = g;
                end
            end else if (tx_ready) begin
                void'(q.pop_front());
            end
            tick();
        end
    endtask

    initial begin
        tbl[0] = '{4'b0100, 64'h0000_1234_0000_0000, 2, 16'h1234};
        tbl[1] = '{4'b1000, 64'hABCD_0000_0000_0000, 3, 16'hABCD};
        tbl[2] = '{4'b1010, 64'h5555_0000_7E81_0000, 1, 16'h7E81};
        tbl[3] = '{4'b1111, 64'h3333_2222_1111_FFFF, 0, 16'hFFFF};

        // Reset state, and tx_ready alone in IDLE does nothing.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_tx_valid", tx_valid, 0);
            chk("rst_tx_data", tx_data, 8'h00);
            chk("rst_busy", busy, 0);
            chk("rst_grant_id", grant_id, 0);
            chk("rst_req_ready", req_ready, 0);
            tick();
        end

        for (int v = 0; v < 4; v++) begin
            do_reset();
            req_data  = tbl[v].data;
            req_valid = tbl[v].valid;
            run_packet(tbl[v].exp_ch, tbl[v].exp_word, 1'b0, 16'h0);
            req_valid = '0;
            @(negedge clk);
            chk("post_busy", busy, 0);
            chk("post_tx_valid", tx_valid, 0);
            chk("post_req_ready", req_ready, 0);
            tick();
        end

        // All channels continuously valid: strict rotation 0,1,2,3,0.
        do_reset();
        req_data  = 64'h3333_2222_1111_0000;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) run_packet(k % 4, 16'(16'h1111 * (k % 4)), 1'b0, 16'h0);
        req_valid = '0;

        // Sample changes right after capture must not reach the packet.
        do_reset();
        req_data[31:16] = 16'hBEEF;
        req_valid       = 4'b0010;
        run_packet(1, 16'hBEEF, 1'b1, 16'h0000);
        req_valid = '0;

        // Backpressure holds the byte and state.
        do_reset();
        tx_ready         = 1'b0;
        req_data[47:32]  = 16'h1234;
        req_valid        = 4'b0100;
        @(negedge clk);
        chk("bp_req_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_data", tx_data, 8'hA5);
            chk("bp_hold_valid", tx_valid, 1);
            tick();
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_data", tx_data, 8'hA5);
        tick();
        @(negedge clk);
        chk("bp_next_data", tx_data, 8'h02);
        drain();

        // Reset during the MSB byte aborts at once; recovery favours channel 0.
        do_reset();
        req_data  = 64'hABCD_0000_0000_CAFE;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        chk("mid_msb_data", tx_data, 8'hCA);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        req_valid = 4'b1001;
        tick();
        rst_n = 1'b1;
        run_packet(0, 16'hCAFE, 1'b0, 16'h0);
        req_valid = '0;

        random_test(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, limit 1000000");
        $fatal(1);
    end

endmodule
`default_nettype wire
